// File: rtl/siso_frame_deser.sv
// Serial frame deserializer: start(1), WIDTH data bits LSB first, optional even
// parity (`PARITY_EN), stop(0); parallel word out with valid/ready handshake.
module siso_frame_deser #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             si,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  input  logic             ready,
  output logic             frame_err,
  output logic             parity_err,
  output logic             overrun
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

`ifdef PARITY_EN
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
`endif

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               valid_q, valid_d;
  logic               ferr_q, ferr_d;
  logic               ovr_q, ovr_d;
  logic               par_mis;
  logic               good;
`ifdef PARITY_EN
  logic               perr_q, perr_d;
  logic               par_mis_q, par_mis_d;
`endif

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shreg_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
`ifdef PARITY_EN
      perr_q    <= 1'b0;
      par_mis_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
`ifdef PARITY_EN
      perr_q    <= perr_d;
      par_mis_q <= par_mis_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    good    = 1'b0;
`ifdef PARITY_EN
    perr_d    = 1'b0;
    par_mis_d = par_mis_q;
    par_mis   = par_mis_q;
`else
    par_mis   = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        // Only a definite 1 starts a frame; 0 or X keeps waiting.
        if (si) begin
          state_d = DATA;
          cnt_d   = '0;
          shreg_d = '0;
`ifdef PARITY_EN
          par_mis_d = 1'b0;
`endif
        end
      end
      DATA: begin
        shreg_d[cnt_q] = si;
        if (cnt_q == LAST_BIT) begin
`ifdef PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef PARITY_EN
      PARITY: begin
        par_mis_d = (^shreg_q) ^ si;
        state_d   = STOP;
      end
`endif
      STOP: begin
        state_d = IDLE;
        if (!si && !par_mis) begin
          good = 1'b1;
        end else begin
          ferr_d = si;
`ifdef PARITY_EN
          perr_d = par_mis;
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    // Consume first, so a load on the same edge as an accept wins.
    if (valid_q && ready) valid_d = 1'b0;
    if (good) begin
      if (!valid_q || ready) begin
        data_d  = shreg_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  assign data_out  = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
`ifdef PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_siso_frame_deser.sv
// Directed self-checking bench for siso_frame_deser (scoreboard of loaded words).
module tb_siso_frame_deser;
  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         clear;
  logic         si;
  logic [W-1:0] data_out;
  logic         valid;
  logic         ready;
  logic         frame_err;
  logic         parity_err;
  logic         overrun;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  siso_frame_deser #(.WIDTH(W)) dut (
    .clk(clk), .clear(clear), .si(si), .data_out(data_out), .valid(valid),
    .ready(ready), .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_load(input string tag);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=empty_queue expected=word", tag);
    end else begin
      chk(tag, 32'(data_out), 32'(exp_q.pop_front()));
    end
  endtask

  // Drive one bit, let the edge sample it, return 1 time unit after the edge.
  task automatic bit_(input logic b);
    si = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_body(input logic [W-1:0] d, input logic par_flip);
    bit_(1'b1);
    for (int i = 0; i < int'(W); i++) bit_(d[i]);
`ifdef PARITY_EN
    bit_((^d) ^ par_flip);
`else
    if (par_flip) $display("note: parity flip ignored without parity");
`endif
  endtask

  task automatic send_frame(input logic [W-1:0] d, input logic stop, input logic par_flip);
    send_body(d, par_flip);
    bit_(stop);
  endtask

  task automatic chk_pulses(input string tag, input logic fe, input logic pe, input logic ov);
    chk({tag, "_frame_err"}, 32'(frame_err), 32'(fe));
    chk({tag, "_parity_err"}, 32'(parity_err), 32'(pe));
    chk({tag, "_overrun"}, 32'(overrun), 32'(ov));
  endtask

  initial begin
    clear = 1'b1; si = 1'b0; ready = 1'b0;
    #1;
    chk("rst_valid", 32'(valid), 0);
    chk("rst_data", 32'(data_out), 0);
    chk_pulses("rst", 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    clear = 1'b0;
    bit_(1'b0);

    // Basic frame 0xA5, ready held high.
    ready = 1'b1;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b0, 1'b0);
    chk("a5_valid", 32'(valid), 1);
    chk_load("a5_data");
    chk_pulses("a5", 1'b0, 1'b0, 1'b0);
    bit_(1'b0);
    chk("a5_valid_fall", 32'(valid), 0);

    // Bad stop bit, then a good frame two cycles later.
    send_frame(8'h3C, 1'b1, 1'b0);
    chk_pulses("badstop", 1'b1, 1'b0, 1'b0);
    chk("badstop_valid", 32'(valid), 0);
    bit_(1'b0);
    chk("badstop_pulse_end", 32'(frame_err), 0);
    bit_(1'b0);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b0, 1'b0);
    chk("x81_valid", 32'(valid), 1);
    chk_load("x81_data");
    bit_(1'b0);

    // Overrun: 0x11 held, 0x22 dropped.
    ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b0, 1'b0);
    chk("x11_valid", 32'(valid), 1);
    chk_load("x11_data");
    chk_pulses("x11", 1'b0, 1'b0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b0);
    chk_pulses("x22_ovr", 1'b0, 1'b0, 1'b1);
    chk("x22_valid_held", 32'(valid), 1);
    chk("x22_data_held", 32'(data_out), 32'h11);
    ready = 1'b1;
    bit_(1'b0);
    chk("ovr_accept_valid", 32'(valid), 0);
    chk("ovr_accept_data", 32'(data_out), 32'h11);
    chk("ovr_pulse_end", 32'(overrun), 0);

    // Accept and load on the same edge.
    ready = 1'b0;
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b0, 1'b0);
    chk_load("x55_data");
    bit_(1'b0);
    exp_q.push_back(8'h66);
    send_body(8'h66, 1'b0);
    ready = 1'b1;
    bit_(1'b0);
    chk("x66_valid", 32'(valid), 1);
    chk_load("x66_data");
    chk_pulses("x66", 1'b0, 1'b0, 1'b0);
    bit_(1'b0);
    chk("x66_valid_fall", 32'(valid), 0);

`ifdef PARITY_EN
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b0, 1'b0);
    chk("par_ok_valid", 32'(valid), 1);
    chk_load("par_ok_data");
    chk_pulses("par_ok", 1'b0, 1'b0, 1'b0);
    bit_(1'b0);
    send_frame(8'h07, 1'b0, 1'b1);
    chk_pulses("par_bad", 1'b0, 1'b1, 1'b0);
    chk("par_bad_valid", 32'(valid), 0);
    bit_(1'b0);
    send_frame(8'h07, 1'b1, 1'b1);
    chk_pulses("par_both", 1'b1, 1'b1, 1'b0);
    chk("par_both_valid", 32'(valid), 0);
    bit_(1'b0);
`endif

    // clear mid-frame with a held word; remaining bits are all 0.
    ready = 1'b0;
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b0, 1'b0);
    chk_load("x5a_data");
    bit_(1'b0);
    bit_(1'b1);
    for (int i = 0; i < 4; i++) bit_(1'b1);
    clear = 1'b1;
    si = 1'b0;
    #1;
    chk("clr_valid", 32'(valid), 0);
    chk("clr_data", 32'(data_out), 0);
    chk_pulses("clr", 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    clear = 1'b0;
    for (int i = 0; i < 6; i++) bit_(1'b0);
    chk("clr_ignored_valid", 32'(valid), 0);
    chk_pulses("clr_ignored", 1'b0, 1'b0, 1'b0);
    ready = 1'b1;
    exp_q.push_back(8'hF0);
    send_frame(8'hF0, 1'b0, 1'b0);
    chk("xf0_valid", 32'(valid), 1);
    chk_load("xf0_data");
    bit_(1'b0);
    chk("xf0_valid_fall", 32'(valid), 0);
    chk("queue_empty", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
